// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache in front of
// a 64-bit-block SRAM controller. Read hits complete combinationally in the same cycle.
module cache_controller #(
   parameter logic [31:0] BASE_ADDR = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_write,
   output logic        sram_read,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);

   typedef enum logic [1:0] {StIdle, StReadMiss, StWrite} state_e;

   state_e state_q, state_d;

   logic [63:0]      data_q [2][64];
   logic [9:0]       tag_q  [2][64];
   logic [1:0][63:0] valid_q;
   logic [63:0]      lru_q;

   logic [31:0] offs;
   logic        word_sel;
   logic [5:0]  idx;
   logic [9:0]  tag;
   logic [1:0]  hit;
   logic        hit_way;
   logic        victim;
   logic [63:0] hit_line;
   logic        fill_en;
   logic        inval_en;
   logic        lru_upd;
   logic        lru_val;
   logic        unused_bits;

   assign offs     = address - BASE_ADDR;
   assign word_sel = offs[2];
   assign idx      = offs[8:3];
   assign tag      = offs[18:9];
   assign unused_bits = ^{offs[31:19], offs[1:0]};

   assign sram_address = address;
   assign sram_wdata   = wdata;

   assign hit[0]   = valid_q[0][idx] && (tag_q[0][idx] == tag);
   assign hit[1]   = valid_q[1][idx] && (tag_q[1][idx] == tag);
   // A tag is never resident in both ways, so way1's hit flag alone names the way.
   assign hit_way  = hit[1];
   assign hit_line = data_q[hit_way][idx];
   assign victim   = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];

   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      rdata      = '0;
      sram_read  = 1'b0;
      sram_write = 1'b0;
      fill_en    = 1'b0;
      inval_en   = 1'b0;
      lru_upd    = 1'b0;
      lru_val    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (MEM_W_EN) begin
               inval_en = |hit;
               state_d  = StWrite;
            end else if (MEM_R_EN) begin
               if (|hit) begin
                  ready   = 1'b1;
                  rdata   = word_sel ? hit_line[63:32] : hit_line[31:0];
                  lru_upd = 1'b1;
                  lru_val = ~hit_way;
               end else begin
                  state_d = StReadMiss;
               end
            end else begin
               ready = 1'b1;
            end
         end
         StReadMiss: begin
            sram_read = 1'b1;
            if (sram_ready) begin
               ready   = 1'b1;
               rdata   = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
               fill_en = 1'b1;
               lru_upd = 1'b1;
               lru_val = ~victim;
               state_d = StIdle;
            end
         end
         StWrite: begin
            sram_write = 1'b1;
            if (sram_ready) begin
               ready   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         valid_q <= '0;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         if (fill_en) begin
            valid_q[victim][idx] <= 1'b1;
         end
         if (inval_en) begin
            valid_q[hit_way][idx] <= 1'b0;
         end
         if (lru_upd) begin
            lru_q[idx] <= lru_val;
         end
      end
   end

   // Payload arrays stay unreset; valid bits gate every hit.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[victim][idx] <= sram_rdata;
         tag_q[victim][idx]  <= tag;
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Randomised bench: a behavioural set/way/LRU model plus a backing-memory SRAM responder
// predicts hit/miss latency, returned data and SRAM request lines for each access.
module tb_cache_controller;

   localparam logic [31:0] BASE = 32'd1024;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_write;
   logic        sram_read;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   int n_checks = 0;
   int n_fail   = 0;

   cache_controller #(.BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wdata        (wdata),
      .MEM_R_EN     (MEM_R_EN),
      .MEM_W_EN     (MEM_W_EN),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_write   (sram_write),
      .sram_read    (sram_read),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Backing store: word-addressed, unwritten words hold an address-derived pattern.
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] mem_word(input logic [29:0] k);
      if (mem.exists(int'(k))) return mem[int'(k)];
      return ({2'b00, k} * 32'h9E37_79B1) ^ 32'h0000_00A0;
   endfunction

   // Cache model: what each set holds, as a list of (valid, tag) per way, plus LRU pointer.
   bit         m_valid [64][2];
   logic [9:0] m_tag   [64][2];
   int         m_lru   [64];

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         m_valid[s][0] = 0;
         m_valid[s][1] = 0;
         m_lru[s]      = 0;
      end
   endtask

   function automatic int model_lookup(input int s, input logic [9:0] t);
      for (int w = 0; w < 2; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) return w;
      return -1;
   endfunction

   task automatic idle_check();
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      sram_ready = 1'($urandom_range(0, 1));
      #1;
      check("idle_ready", ready, 1);
      check("idle_sram_read", sram_read, 0);
      check("idle_sram_write", sram_write, 0);
      @(negedge clk);
      sram_ready = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge with the request dropped.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd);
      logic [31:0] a;
      int          s, way, lat, cnt, cyc, vic;
      bit          exp_hit, done, saw_rd, saw_wr, both, addr_ok;
      logic [31:0] got;
      a       = addr - BASE;
      s       = int'(a[8:3]);
      way     = model_lookup(s, a[18:9]);
      exp_hit = rd && !wr && (way >= 0);
      lat     = $urandom_range(0, 3);
      cnt = 0; cyc = 0; done = 0; saw_rd = 0; saw_wr = 0; both = 0; addr_ok = 1;
      got = '0;
      address  = addr;
      wdata    = wd;
      MEM_R_EN = rd;
      MEM_W_EN = wr;
      while (!done && cyc < 40) begin
         #1;
         if (sram_read && sram_write) both = 1;
         saw_rd |= sram_read;
         saw_wr |= sram_write;
         if (sram_read || sram_write) begin
            if (sram_address !== addr || sram_wdata !== wd) addr_ok = 0;
            sram_ready = (cnt == lat);
            sram_rdata = {mem_word({addr[31:3], 1'b1}), mem_word({addr[31:3], 1'b0})};
            cnt++;
         end else begin
            sram_ready = 1'($urandom_range(0, 1));
            sram_rdata = {$urandom, $urandom};
         end
         #1;
         cyc++;
         if (ready) begin
            done = 1;
            got  = rdata;
         end
         @(negedge clk);
      end
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      sram_ready = 1'b0;
      check("completed", done, 1);
      check("stall_cycles", cyc, exp_hit ? 1 : lat + 2);
      if (rd && !wr) check("rdata", got, mem_word(addr[31:2]));
      check("sram_read_seen", saw_rd, rd && !wr && !exp_hit);
      check("sram_write_seen", saw_wr, wr);
      check("sram_rw_exclusive", both, 0);
      check("sram_addr_wdata_copy", addr_ok, 1);
      if (wr) begin
         if (way >= 0) m_valid[s][way] = 0;
         mem[int'(addr[31:2])] = wd;
      end else if (rd) begin
         if (way >= 0) begin
            m_lru[s] = 1 - way;
         end else begin
            vic = !m_valid[s][0] ? 0 : !m_valid[s][1] ? 1 : m_lru[s];
            m_valid[s][vic] = 1;
            m_tag[s][vic]   = a[18:9];
            m_lru[s]        = 1 - vic;
         end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      int          tsel;
      logic [9:0]  t;
      logic [5:0]  ix;
      tsel = $urandom_range(0, 4);
      t    = (tsel == 4) ? 10'd1023 : 10'(tsel);
      case ($urandom_range(0, 2))
         0:       ix = 6'd0;
         1:       ix = 6'd1;
         default: ix = 6'd63;
      endcase
      a = {13'd0, t, ix, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      return a + BASE;
   endfunction

   initial begin
      rst        = 1'b1;
      address    = '0;
      wdata      = '0;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      sram_rdata = '0;
      sram_ready = 1'b0;
      model_reset();
      #2;
      check("rst_sram_read", sram_read, 0);
      check("rst_sram_write", sram_write, 0);
      check("rst_ready", ready, 1);
      @(negedge clk);
      rst = 1'b0;
      idle_check();

      // Fill then hit both words of a line.
      do_access(1, 0, 32'd1024, 0);
      do_access(1, 0, 32'd1024, 0);
      do_access(1, 0, 32'd1028, 0);
      // Three tags competing for set 0.
      do_access(1, 0, 32'd1536, 0);
      do_access(1, 0, 32'd2048, 0);
      do_access(1, 0, 32'd1024, 0);
      do_access(1, 0, 32'd1536, 0);
      do_access(1, 0, 32'd1024, 0);
      // Write-through invalidates a resident line.
      do_access(0, 1, 32'd1024, 32'd5);
      idle_check();
      do_access(1, 0, 32'd1024, 0);
      // No write-allocate.
      do_access(0, 1, 32'd1032, 32'h1234_5678);
      do_access(1, 0, 32'd1032, 0);
      // Simultaneous read and write takes the write path.
      do_access(1, 1, 32'd1024, 32'hCAFE_0001);
      do_access(1, 0, 32'd1024, 0);

      // Reset in the middle of a read miss.
      address  = 32'd1040;
      MEM_R_EN = 1'b1;
      @(negedge clk);
      #1;
      check("miss_sram_read", sram_read, 1);
      rst = 1'b1;
      #1;
      check("rst_drops_sram_read", sram_read, 0);
      MEM_R_EN = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle_check();
      do_access(1, 0, 32'd1040, 0);
      do_access(1, 0, 32'd1024, 0);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    do_access(0, 1, rand_addr(), $urandom);
            2:       do_access(1, 1, rand_addr(), $urandom);
            3:       idle_check();
            default: do_access(1, 0, rand_addr(), 0);
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
